// File: rtl/weight_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : weight_fetch_ctrl
// Description : Burst reader that pulls weight words from a BRAM port and
//               streams them over a ready/valid interface via a 2-entry FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [7:0]  num_words,
    output logic        busy,
    output logic        done,
    output logic [31:0] bram_addr,
    output logic        bram_en,
    output logic [3:0]  bram_wen,
    output logic [31:0] bram_din,
    input  logic [31:0] bram_dout,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [7:0]  r_num;
    logic [7:0]  r_issued;
    logic [7:0]  r_xfer;
    logic        r_inflight;
    logic [31:0] r_fifo [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    logic        w_pop;
    logic        w_issue;
    logic [2:0]  w_occ;
    logic [2:0]  w_limit;

    assign m_valid   = (r_count != 2'd0);
    assign m_data    = r_fifo[r_rd_ptr];
    assign w_pop     = m_valid && m_ready;

    // A word popped this cycle frees a slot for a read issued this cycle,
    // which is what lets the stream run without bubbles on a 2-deep FIFO.
    assign w_occ     = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_limit   = 3'd2 + {2'b00, w_pop};
    assign w_issue   = (r_state == S_FETCH) && (w_occ < w_limit);

    assign bram_en   = w_issue;
    assign bram_addr = r_addr;
    assign bram_wen  = 4'b0000;
    assign bram_din  = 32'd0;
    assign busy      = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= 32'd0;
            r_num      <= 8'd0;
            r_issued   <= 8'd0;
            r_xfer     <= 8'd0;
            r_inflight <= 1'b0;
            r_fifo[0]  <= 32'd0;
            r_fifo[1]  <= 32'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            // Read data is valid the cycle after the enable; capture it then.
            r_inflight <= w_issue;
            if (r_inflight) begin
                r_fifo[r_wr_ptr] <= bram_dout;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                r_xfer   <= r_xfer + 8'd1;
            end
            case ({r_inflight, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            if (w_issue) begin
                r_addr   <= r_addr + 32'd4;
                r_issued <= r_issued + 8'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr   <= base_addr;
                        r_num    <= num_words;
                        r_issued <= 8'd0;
                        r_xfer   <= 8'd0;
                        r_state  <= (num_words == 8'd0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_issue && (r_issued == r_num - 8'd1))
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_pop && (r_xfer == r_num - 8'd1))
                        r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_weight_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_fetch_ctrl
// Description : Table-driven, scoreboard-checked bench for weight_fetch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [7:0]  num_words;
    logic        busy;
    logic        done;
    logic [31:0] bram_addr;
    logic        bram_en;
    logic [3:0]  bram_wen;
    logic [31:0] bram_din;
    logic [31:0] bram_dout = 32'd0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic [31:0] base;
        int          n;
        int          stall_at;
        int          stall_len;
        int          repulse_at;
        int          exp_done;
    } vec_t;

    weight_fetch_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .bram_addr (bram_addr),
        .bram_en   (bram_en),
        .bram_wen  (bram_wen),
        .bram_din  (bram_din),
        .bram_dout (bram_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
    );

    always #5 clk = ~clk;

    // Memory content: word at byte address a is (a/4)+1, so mem[i]=i+1 from 0.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {2'b00, a[31:2]} + 32'd1;
    endfunction

    always @(posedge clk) begin
        if (bram_en === 1'b1) bram_dout <= word_at(bram_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic run_burst(input vec_t v);
        int   issued = 0;
        int   xfers = 0;
        logic done_seen = 1'b0;
        logic prev_stall = 1'b0;
        logic [31:0] prev_data = 32'd0;
        for (int k = 0; k < v.n; k++) exp_q.push_back(word_at(v.base + 32'(4 * k)));
        start     = 1'b1;
        base_addr = v.base;
        num_words = 8'(v.n);
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 400 && !done_seen; cyc++) begin
            m_ready = !(v.stall_at >= 0 && cyc >= v.stall_at && cyc < v.stall_at + v.stall_len);
            if (cyc == v.repulse_at) begin
                start     = 1'b1;
                base_addr = 32'hDEAD_0000;
                num_words = 8'd9;
            end else begin
                start = 1'b0;
            end
            #1;
            check("bram_wen", {28'd0, bram_wen}, 32'd0);
            check("bram_din", bram_din, 32'd0);
            if (prev_stall) begin
                check("stall_valid", {31'd0, m_valid}, 32'd1);
                check("stall_data", m_data, prev_data);
            end
            if (bram_en) begin
                check("bram_addr", bram_addr, v.base + 32'(4 * issued));
                issued++;
            end
            if (v.stall_at < 0 && v.n > 0) begin
                if (cyc == 1) check("first_en", {31'd0, bram_en}, 32'd1);
                if (cyc < 3) check("early_valid", {31'd0, m_valid}, 32'd0);
                if (cyc >= 3 && cyc <= v.n + 2) check("no_bubble", {31'd0, m_valid}, 32'd1);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("extra_word", m_data, 32'hFFFF_FFFF);
                else check("m_data", m_data, exp_q.pop_front());
                xfers++;
            end
            check("outstanding_le2", (issued - xfers <= 2) ? 32'd1 : 32'd0, 32'd1);
            check("reads_le_n", (issued <= v.n) ? 32'd1 : 32'd0, 32'd1);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (done) begin
                done_seen = 1'b1;
                check("busy_in_done", {31'd0, busy}, 32'd0);
                if (v.exp_done >= 0) check("done_cycle", 32'(cyc), 32'(v.exp_done));
                check("words_left", 32'(exp_q.size()), 32'd0);
                check("reads_issued", 32'(issued), 32'(v.n));
            end else begin
                check("busy", {31'd0, busy}, 32'd1);
            end
            @(posedge clk); #1;
        end
        start   = 1'b0;
        m_ready = 1'b1;
        if (!done_seen) check("done_timeout", 32'd0, 32'd1);
        #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_valid", {31'd0, m_valid}, 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_bram_en"}, {31'd0, bram_en}, 32'd0);
        check({tag, "_bram_addr"}, bram_addr, 32'd0);
        check({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
        check({tag, "_m_data"}, m_data, 32'd0);
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{32'h0000_0000, 4, -1, 0, -1, 7};
        vecs[1] = '{32'h0000_0100, 6,  4, 5, -1, -1};
        vecs[2] = '{32'h0000_0000, 0, -1, 0, -1, 1};
        vecs[3] = '{32'hFFFF_FFFC, 2, -1, 0, -1, 5};
        vecs[4] = '{32'h0000_0040, 5, -1, 0,  2, 8};
        vecs[5] = '{32'h0000_0200, 3,  3, 2, -1, -1};

        // Reset with start held high: reset must win.
        rst = 1'b1; start = 1'b1; base_addr = 32'h1234_5678; num_words = 8'd3; m_ready = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        check_reset_outputs("reset");
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #2;
        check("post_reset_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_burst(vecs[i]);
            @(posedge clk); #1;
        end

        // Reset two cycles into an 8-word burst, with a read in flight.
        m_ready = 1'b0; start = 1'b1; base_addr = 32'h0; num_words = 8'd8;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; m_ready = 1'b1; #1;
        check_reset_outputs("midburst_reset");
        @(posedge clk); #2;
        check("no_stale_push", {31'd0, m_valid}, 32'd0);
        run_burst('{32'h0000_0080, 1, -1, 0, -1, 4});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
